// File: rtl/hazard_if.sv
// Handshake bundle between the pipeline datapath and the hazard controller.
// The datapath side (master) supplies stage register fields; the controller (slave) returns selects and stalls.
interface hazard_if #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
);
    logic [REG_AW-1:0] Rs1_D;
    logic [REG_AW-1:0] Rs2_D;
    logic [REG_AW-1:0] Rs1_E;
    logic [REG_AW-1:0] Rs2_E;
    logic [REG_AW-1:0] RD_E;
    logic [REG_AW-1:0] RD_M;
    logic [REG_AW-1:0] RD_W;
    logic              RegWriteM;
    logic              RegWriteW;
    logic              MemReadE;
    logic              PCSrcE;
    logic              MdOpD;
    logic              MdStartE;

    logic [1:0]        ForwardAE;
    logic [1:0]        ForwardBE;
    logic              StallF;
    logic              StallD;
    logic              FlushD;
    logic              FlushE;
    logic              MdBusy;
    logic              MdDone;
    logic [REG_AW-1:0] MdRd;
    logic [CNT_W-1:0]  StallCnt;

    modport master (
        output Rs1_D, Rs2_D, Rs1_E, Rs2_E, RD_E, RD_M, RD_W,
        output RegWriteM, RegWriteW, MemReadE, PCSrcE, MdOpD, MdStartE,
        input  ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE,
        input  MdBusy, MdDone, MdRd, StallCnt
    );

    modport slave (
        input  Rs1_D, Rs2_D, Rs1_E, Rs2_E, RD_E, RD_M, RD_W,
        input  RegWriteM, RegWriteW, MemReadE, PCSrcE, MdOpD, MdStartE,
        output ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE,
        output MdBusy, MdDone, MdRd, StallCnt
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage core: operand forwarding, load-use and
// multi-cycle-unit interlocks, branch flush, and a saturating stall counter.
module hazard_ctrl #(
    parameter int REG_AW = 5,
    parameter int MD_LAT = 4,
    parameter int CNT_W  = 16
) (
    input  logic   clk,
    input  logic   rst,
    hazard_if.slave hz
);

    localparam int LAT_W = 5;
    localparam logic [LAT_W-1:0] LAT_M1 = LAT_W'(MD_LAT - 1);

    typedef enum logic {IDLE, BUSY} md_state_e;

    md_state_e         state_q, state_d;
    logic [LAT_W-1:0]  cnt_q, cnt_d;
    logic [REG_AW-1:0] md_rd_q, md_rd_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    logic [1:0] fwd_a, fwd_b;
    logic       md_busy, md_done;
    logic       lu, md_raw, md_str, stall;
    logic       stall_f, stall_d, flush_d, flush_e;

    function automatic logic [1:0] fwd_sel(
        input logic [REG_AW-1:0] rs,
        input logic [REG_AW-1:0] rd_m,
        input logic              we_m,
        input logic [REG_AW-1:0] rd_w,
        input logic              we_w
    );
        logic [1:0] sel;
        sel = 2'd0;
        if (we_m && rd_m != '0 && rd_m == rs)
            sel = 2'd2;
        else if (we_w && rd_w != '0 && rd_w == rs)
            sel = 2'd1;
        return sel;
    endfunction

    function automatic logic src_hit(
        input logic [REG_AW-1:0] rd,
        input logic [REG_AW-1:0] rs1,
        input logic [REG_AW-1:0] rs2
    );
        return (rd != '0) && (rd == rs1 || rd == rs2);
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Hazard decode; every combinational output is held low while in reset.
    always_comb begin
        fwd_a   = fwd_sel(hz.Rs1_E, hz.RD_M, hz.RegWriteM, hz.RD_W, hz.RegWriteW);
        fwd_b   = fwd_sel(hz.Rs2_E, hz.RD_M, hz.RegWriteM, hz.RD_W, hz.RegWriteW);
        md_busy = (state_q == BUSY);
        md_done = md_busy && (cnt_q == '0);

        lu     = hz.MemReadE && src_hit(hz.RD_E, hz.Rs1_D, hz.Rs2_D);
        md_raw = (md_busy && src_hit(md_rd_q, hz.Rs1_D, hz.Rs2_D)) ||
                 (hz.MdStartE && src_hit(hz.RD_E, hz.Rs1_D, hz.Rs2_D));
        md_str = hz.MdOpD && (md_busy || hz.MdStartE);
        stall  = lu || md_raw || md_str;

        stall_f = 1'b0;
        stall_d = 1'b0;
        flush_d = 1'b0;
        flush_e = 1'b0;
        if (hz.PCSrcE) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
        end else begin
            stall_f = stall;
            stall_d = stall;
            flush_e = stall;
        end

        if (rst) begin
            fwd_a   = 2'd0;
            fwd_b   = 2'd0;
            md_busy = 1'b0;
            md_done = 1'b0;
            stall_f = 1'b0;
            stall_d = 1'b0;
            flush_d = 1'b0;
            flush_e = 1'b0;
        end
    end

    // Tracker next state; a start seen while BUSY is dropped because the
    // structural interlock should already have kept it out of E.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        md_rd_d     = md_rd_q;
        stall_cnt_d = stall_d ? sat_inc(stall_cnt_q) : stall_cnt_q;
        case (state_q)
            IDLE: begin
                if (hz.MdStartE) begin
                    state_d = BUSY;
                    cnt_d   = LAT_M1;
                    md_rd_d = hz.RD_E;
                end
            end
            BUSY: begin
                if (cnt_q == '0)
                    state_d = IDLE;
                else
                    cnt_d = cnt_q - LAT_W'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            md_rd_q     <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            md_rd_q     <= md_rd_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign hz.ForwardAE = fwd_a;
    assign hz.ForwardBE = fwd_b;
    assign hz.StallF    = stall_f;
    assign hz.StallD    = stall_d;
    assign hz.FlushD    = flush_d;
    assign hz.FlushE    = flush_e;
    assign hz.MdBusy    = md_busy;
    assign hz.MdDone    = md_done;
    assign hz.MdRd      = md_rd_q;
    assign hz.StallCnt  = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl (MD_LAT = 4, CNT_W = 4): inputs change on the
// falling edge, outputs are checked 1 time unit later.
module tb_hazard_ctrl;

    localparam int REG_AW = 5;
    localparam int MD_LAT = 4;
    localparam int CNT_W  = 4;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    hazard_if #(.REG_AW(REG_AW), .CNT_W(CNT_W)) hif ();

    hazard_ctrl #(.REG_AW(REG_AW), .MD_LAT(MD_LAT), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hif.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        hif.Rs1_D = '0; hif.Rs2_D = '0; hif.Rs1_E = '0; hif.Rs2_E = '0;
        hif.RD_E  = '0; hif.RD_M  = '0; hif.RD_W  = '0;
        hif.RegWriteM = 1'b0; hif.RegWriteW = 1'b0; hif.MemReadE = 1'b0;
        hif.PCSrcE = 1'b0; hif.MdOpD = 1'b0; hif.MdStartE = 1'b0;
    endtask

    task automatic next_cycle();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();

        // Reset: outputs forced low even with matching hazards present
        next_cycle();
        hif.RD_M = 5'd5; hif.Rs1_E = 5'd5; hif.RegWriteM = 1'b1;
        hif.MemReadE = 1'b1; hif.RD_E = 5'd7; hif.Rs1_D = 5'd7; hif.PCSrcE = 1'b1;
        #1;
        chk("rst_fwdA", hif.ForwardAE, 0);
        chk("rst_stallD", hif.StallD, 0);
        chk("rst_flushD", hif.FlushD, 0);
        chk("rst_flushE", hif.FlushE, 0);
        chk("rst_busy", hif.MdBusy, 0);
        chk("rst_mdrd", hif.MdRd, 0);
        chk("rst_cnt", hif.StallCnt, 0);
        next_cycle();
        rst = 1'b0;
        clear_inputs();

        // Forwarding priority
        next_cycle();
        hif.RD_M = 5'd5; hif.RD_W = 5'd5; hif.Rs1_E = 5'd5;
        hif.RegWriteM = 1'b1; hif.RegWriteW = 1'b1;
        #1;
        chk("fwdA_M", hif.ForwardAE, 2);
        chk("fwdB_none", hif.ForwardBE, 0);
        hif.RegWriteM = 1'b0; hif.Rs2_E = 5'd5;
        #1;
        chk("fwdA_W", hif.ForwardAE, 1);
        chk("fwdB_W", hif.ForwardBE, 1);
        hif.RegWriteM = 1'b1; hif.Rs1_E = 5'd0; hif.RD_M = 5'd0; hif.RD_W = 5'd0;
        #1;
        chk("fwdA_r0", hif.ForwardAE, 0);
        chk("fwd_stall_none", hif.StallD, 0);
        clear_inputs();

        // Load-use
        next_cycle();
        hif.MemReadE = 1'b1; hif.RD_E = 5'd7; hif.Rs2_D = 5'd7;
        #1;
        chk("lu_stallF", hif.StallF, 1);
        chk("lu_stallD", hif.StallD, 1);
        chk("lu_flushE", hif.FlushE, 1);
        chk("lu_flushD", hif.FlushD, 0);
        next_cycle();
        hif.RD_E = 5'd0; hif.Rs2_D = 5'd0;
        #1;
        chk("lu_cnt1", hif.StallCnt, 1);
        chk("lu_r0_stallD", hif.StallD, 0);
        next_cycle();
        clear_inputs();
        #1;
        chk("lu_r0_cnt", hif.StallCnt, 1);

        // MD latency with a dependent op in D
        next_cycle();
        hif.MdStartE = 1'b1; hif.RD_E = 5'd9; hif.Rs1_D = 5'd9;
        #1;
        chk("md_issue_stallD", hif.StallD, 1);
        chk("md_issue_busy", hif.MdBusy, 0);
        for (int i = 1; i <= 4; i++) begin
            next_cycle();
            hif.MdStartE = 1'b0; hif.RD_E = 5'd0;
            #1;
            chk($sformatf("md_busy_c%0d", i), hif.MdBusy, 1);
            chk($sformatf("md_rd_c%0d", i), hif.MdRd, 9);
            chk($sformatf("md_stallD_c%0d", i), hif.StallD, 1);
            chk($sformatf("md_done_c%0d", i), hif.MdDone, (i == 4) ? 1 : 0);
        end
        next_cycle();
        #1;
        chk("md_after_busy", hif.MdBusy, 0);
        chk("md_after_stallD", hif.StallD, 0);
        chk("md_after_done", hif.MdDone, 0);
        chk("md_cnt6", hif.StallCnt, 6);
        clear_inputs();

        // Structural interlock and ignored second start
        next_cycle();
        hif.MdStartE = 1'b1; hif.RD_E = 5'd3;
        #1;
        chk("str_issue_stallD", hif.StallD, 0);
        next_cycle();
        hif.MdStartE = 1'b0; hif.RD_E = 5'd0; hif.MdOpD = 1'b1; hif.Rs1_D = 5'd4;
        #1;
        chk("str_c1_stallD", hif.StallD, 1);
        next_cycle();
        hif.MdStartE = 1'b1; hif.RD_E = 5'd12;
        #1;
        chk("str_c2_stallD", hif.StallD, 1);
        next_cycle();
        hif.MdStartE = 1'b0; hif.RD_E = 5'd0;
        #1;
        chk("str_c3_mdrd", hif.MdRd, 3);
        chk("str_c3_done", hif.MdDone, 0);
        next_cycle();
        #1;
        chk("str_c4_done", hif.MdDone, 1);
        chk("str_c4_stallD", hif.StallD, 1);
        next_cycle();
        #1;
        chk("str_c5_stallD", hif.StallD, 0);
        chk("str_c5_busy", hif.MdBusy, 0);
        chk("str_cnt10", hif.StallCnt, 10);
        clear_inputs();

        // Branch redirect beats load-use; in-flight MD op unaffected
        next_cycle();
        hif.MdStartE = 1'b1; hif.RD_E = 5'd8;
        #1;
        chk("br_issue_stallD", hif.StallD, 0);
        next_cycle();
        hif.MdStartE = 1'b0;
        hif.MemReadE = 1'b1; hif.RD_E = 5'd7; hif.Rs2_D = 5'd7; hif.PCSrcE = 1'b1;
        #1;
        chk("br_flushD", hif.FlushD, 1);
        chk("br_flushE", hif.FlushE, 1);
        chk("br_stallF", hif.StallF, 0);
        chk("br_stallD", hif.StallD, 0);
        chk("br_busy", hif.MdBusy, 1);
        for (int i = 2; i <= 4; i++) begin
            next_cycle();
            clear_inputs();
            #1;
            chk($sformatf("br_done_c%0d", i), hif.MdDone, (i == 4) ? 1 : 0);
        end
        chk("br_cnt10", hif.StallCnt, 10);

        // Reset in the middle of a BUSY period
        next_cycle();
        hif.MdStartE = 1'b1; hif.RD_E = 5'd6;
        next_cycle();
        clear_inputs();
        #1;
        chk("rb_busy", hif.MdBusy, 1);
        next_cycle();
        rst = 1'b1;
        #1;
        chk("rb_in_rst_busy", hif.MdBusy, 0);
        chk("rb_in_rst_done", hif.MdDone, 0);
        next_cycle();
        rst = 1'b0;
        #1;
        chk("rb_after_busy", hif.MdBusy, 0);
        chk("rb_after_done", hif.MdDone, 0);
        chk("rb_after_cnt", hif.StallCnt, 0);
        chk("rb_after_mdrd", hif.MdRd, 0);
        next_cycle();
        #1;
        chk("rb_late_done", hif.MdDone, 0);

        // Saturating stall counter
        hif.MemReadE = 1'b1; hif.RD_E = 5'd7; hif.Rs1_D = 5'd7;
        for (int i = 1; i <= 20; i++) begin
            next_cycle();
            #1;
            if (i == 14) chk("sat_cnt14", hif.StallCnt, 14);
        end
        clear_inputs();
        #1;
        chk("sat_cnt15", hif.StallCnt, 15);
        next_cycle();
        #1;
        chk("sat_hold15", hif.StallCnt, 15);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
